fetch_pc_sequencer: RTL
=======================

FETCH_PC_SEQUENCER -- requirements
Module: fetch_pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, first fetch address after reset.
REQ-002 Parameter EXC_VEC, default 32'hBFC00380, fetch address on exception.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset rst, asynchronous, active-high.
REQ-005 stall_i  input  1  decode not accepting; the instruction beat is held.
REQ-006 br_taken_i  input  1  branch/jump redirect, pulse, asserted only after the delay slot is accepted.
REQ-007 br_target_i  input  32  branch/jump target.
REQ-008 exc_i  input  1  exception redirect to EXC_VEC, pulse.
REQ-009 eret_i  input  1  return redirect to epc_i, pulse.
REQ-010 epc_i  input  32  eret target.
REQ-011 inst_req_o  output  1  instruction memory request valid.
REQ-012 inst_addr_o  output  32  request address, equals fetch_pc.
REQ-013 inst_addr_ok_i  input  1  request accepted this cycle.
REQ-014 inst_data_ok_i  input  1  read data valid this cycle.
REQ-015 inst_rdata_i  input  32  read data.
REQ-016 if_valid_o  output  1  instruction beat valid to decode.
REQ-017 if_pc_o  output  32  PC of the beat.
REQ-018 if_inst_o  output  32  instruction of the beat.
REQ-019 if_adel_o  output  1  beat carries a misaligned-fetch error, no memory access made.

Function
REQ-020 The block SHALL hold a 32-bit fetch_pc register, a discard flag and a 2-bit state: IDLE, REQ, WAIT, OUT.
REQ-021 It SHALL have at most one memory transaction outstanding at a time.
REQ-022 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-023 In REQ with fetch_pc[1:0]==0, inst_req_o SHALL be 1 and inst_addr_o SHALL equal fetch_pc; inst_addr_ok_i=1 -> WAIT.
REQ-024 In REQ with fetch_pc[1:0]!=0, inst_req_o SHALL be 0; next edge loads if_pc_o=fetch_pc, if_inst_o=0, if_adel_o=1, if_valid_o=1 -> OUT.
REQ-025 In WAIT with inst_data_ok_i=1 and discard=0, the block SHALL register if_inst_o=inst_rdata_i, if_pc_o=fetch_pc, if_adel_o=0, if_valid_o=1 -> OUT. The beat appears one cycle after data_ok.
REQ-026 In WAIT with inst_data_ok_i=1 and discard=1, the block SHALL drop the data, clear discard -> REQ.
REQ-027 In OUT with stall_i=0, the block SHALL clear if_valid_o, set fetch_pc=fetch_pc+4 (modulo 2^32, wraps FFFFFFFC->00000000) -> REQ.
REQ-028 In OUT with stall_i=1, all outputs SHALL hold unchanged.
REQ-029 Redirect target priority SHALL be exc_i (EXC_VEC) > eret_i (epc_i) > br_taken_i (br_target_i); simultaneous pulses take only the highest.
REQ-030 A redirect in IDLE or REQ without addr_ok SHALL load fetch_pc=target. The state does not change; in REQ the new address is presented from the next cycle.
REQ-031 A redirect in REQ with inst_addr_ok_i=1 in the same cycle SHALL load fetch_pc=target, set discard=1 -> WAIT.
REQ-032 A redirect in WAIT without data_ok SHALL load fetch_pc=target, set discard=1.
REQ-033 A redirect in WAIT with data_ok in the same cycle SHALL drop the data, load fetch_pc=target, leave discard=0 -> REQ.
REQ-034 A redirect in OUT SHALL clear if_valid_o, load fetch_pc=target (no +4) -> REQ, regardless of stall_i.
REQ-035 inst_req_o SHALL never be asserted in WAIT or OUT.

Reset
REQ-036 On rst=1, asynchronously: state=IDLE, fetch_pc=RESET_PC, discard=0, if_valid_o=0, if_pc_o=0, if_inst_o=0, if_adel_o=0, inst_req_o=0.
REQ-037 rst asserted mid-transaction SHALL abandon it. The memory side SHALL be reset in the same domain; the block ignores any late data_ok belonging to the abandoned transaction.

Verification
REQ-038 Release reset, addr_ok in 1st REQ cycle, data_ok 2 cycles later with 0x24080001, stall_i=0 -> inst_addr_o=BFC00000, if_pc_o=BFC00000, if_inst_o=24080001, then next request at BFC00004.
REQ-039 stall_i=1 for 5 cycles while in OUT -> if_valid_o, if_pc_o and if_inst_o stable 5 cycles, no inst_req_o; release -> request at pc+4.
REQ-040 br_taken_i with target 0xBFC00100 while in WAIT, then data_ok -> data dropped, no if_valid_o, next request at BFC00100, discard cleared.
REQ-041 exc_i, eret_i (epc 0x80001000) and br_taken_i in the same cycle in OUT -> next request at BFC00380.
REQ-042 eret_i with epc_i=0x80000002 -> no inst_req_o, if_valid_o=1 with if_adel_o=1, if_pc_o=80000002.
REQ-043 rst pulsed while in WAIT -> all outputs at reset values immediately, next request at BFC00000.

Source files
------------

// File: rtl/fetch_pc_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_pc_sequencer_if
// Description : Instruction-memory request/response bus between the fetch
//               sequencer (master) and the instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_sequencer_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_addr_ok_i,
        input  inst_data_ok_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_addr_ok_i,
        output inst_data_ok_i,
        output inst_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_pc_sequencer
// Description : Fetch-stage PC sequencer with one outstanding instruction
//               fetch, redirect handling and a registered beat to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [31:0] EXC_VEC  = 32'hBFC00380
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  stall_i,
    input  wire logic                  br_taken_i,
    input  wire logic [31:0]           br_target_i,
    input  wire logic                  exc_i,
    input  wire logic                  eret_i,
    input  wire logic [31:0]           epc_i,
    fetch_pc_sequencer_if.master       mem,
    output logic                       if_valid_o,
    output logic [31:0]                if_pc_o,
    output logic [31:0]                if_inst_o,
    output logic                       if_adel_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    logic [1:0]  state_q,    state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        discard_q,  discard_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q,    if_pc_d;
    logic [31:0] if_inst_q,  if_inst_d;
    logic        if_adel_q,  if_adel_d;

    logic        w_redir;
    logic [31:0] w_redir_pc;
    logic        w_pc_aligned;

    // Exception outranks eret, which outranks a branch.
    always_comb begin
        w_redir    = exc_i | eret_i | br_taken_i;
        w_redir_pc = br_target_i;
        if (exc_i) begin
            w_redir_pc = EXC_VEC;
        end else if (eret_i) begin
            w_redir_pc = epc_i;
        end
    end

    assign w_pc_aligned = (fetch_pc_q[1:0] == 2'b00);

    // State register (asynchronous reset abandons any in-flight fetch).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_inst_q  <= 32'h0;
            if_adel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_adel_q  <= if_adel_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (w_pc_aligned) begin
                    if (mem.inst_addr_ok_i) begin
                        state_d = ST_WAIT;
                    end
                end else if (!w_redir) begin
                    state_d = ST_OUT;
                end
            end
            ST_WAIT: begin
                if (mem.inst_data_ok_i) begin
                    state_d = (w_redir || discard_q) ? ST_REQ : ST_OUT;
                end
            end
            ST_OUT: begin
                if (w_redir || !stall_i) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output logic.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_adel_d  = if_adel_q;

        mem.inst_req_o  = (state_q == ST_REQ) && w_pc_aligned;
        mem.inst_addr_o = fetch_pc_q;
        if_valid_o      = if_valid_q;
        if_pc_o         = if_pc_q;
        if_inst_o       = if_inst_q;
        if_adel_o       = if_adel_q;

        case (state_q)
            ST_IDLE: begin
                if (w_redir) begin
                    fetch_pc_d = w_redir_pc;
                end
            end
            ST_REQ: begin
                if (w_redir) begin
                    fetch_pc_d = w_redir_pc;
                    // The accepted request now belongs to a stale PC.
                    if (w_pc_aligned && mem.inst_addr_ok_i) begin
                        discard_d = 1'b1;
                    end
                end else if (!w_pc_aligned) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = fetch_pc_q;
                    if_inst_d  = 32'h0;
                    if_adel_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem.inst_data_ok_i) begin
                    discard_d = 1'b0;
                    if (w_redir) begin
                        fetch_pc_d = w_redir_pc;
                    end else if (!discard_q) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = fetch_pc_q;
                        if_inst_d  = mem.inst_rdata_i;
                        if_adel_d  = 1'b0;
                    end
                end else if (w_redir) begin
                    fetch_pc_d = w_redir_pc;
                    discard_d  = 1'b1;
                end
            end
            ST_OUT: begin
                if (w_redir) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = w_redir_pc;
                end else if (!stall_i) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            default: begin
                fetch_pc_d = fetch_pc_q;
            end
        endcase
    end

endmodule
`default_nettype wire
